apuracao: RTL and testbench

APURACAO -- requirements
Module: apuracao

---
 rtl/apuracao.sv | 183 ++++++++++++++++++
 tb/tb_apuracao.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apuracao.sv
// apuracao: vote tally for a four-candidate ballot box plus a null count.
// Votes are counted on rising edges of the candidate lines while counting.
// After finish, the four candidate counters are scanned one per clock to find
// the winner or a tie. The result is then held, and proximo steps a readout
// through all five counters.
//
// state     | meaning
// CONTANDO  | accepting votes on rising candidate edges
// APURANDO  | scanning candidates 0..3, one per clock; counters frozen
// RESULTADO | result valid (pronto=1), proximo steps the readout index
// INVALIDO  | unreachable encoding, recovers to CONTANDO on the next edge
module apuracao (
  input  logic       clock,
  input  logic       reset,
  input  logic       candidatoArthur,
  input  logic       candidatoLeandro,
  input  logic       candidatoMateus,
  input  logic       candidatoPablo,
  input  logic       candidatoNulo,
  input  logic       finish,
  input  logic       proximo,
  output logic [1:0] estado,
  output logic [9:0] total_votos,
  output logic [2:0] vencedor,
  output logic       empate,
  output logic       pronto,
  output logic [2:0] exibe_idx,
  output logic [7:0] exibe_votos
);

  typedef enum logic [1:0] {
    CONTANDO  = 2'd0,
    APURANDO  = 2'd1,
    RESULTADO = 2'd2,
    INVALIDO  = 2'd3
  } estado_t;

  localparam logic [2:0] NENHUM = 3'd7;

  estado_t    r_estado;
  logic [4:0] r_cand_prev;
  logic       r_prox_prev;
  logic [7:0] r_cnt [5];
  logic [9:0] r_total;
  logic [1:0] r_scan_idx;
  logic [7:0] r_best;
  logic [2:0] r_vencedor;
  logic       r_empate;
  logic       r_pronto;
  logic [2:0] r_exibe_idx;

  logic [4:0] w_cand;
  logic [4:0] w_rise;
  logic       w_multi;
  logic       w_any;
  logic       w_contando;
  logic [4:0] w_inc;
  logic [7:0] w_scan_cnt;
  logic       w_gt;
  logic       w_empate_next;
  logic       w_prox_rise;

  assign w_cand      = {candidatoNulo, candidatoPablo, candidatoMateus,
                        candidatoLeandro, candidatoArthur};
  assign w_rise      = w_cand & ~r_cand_prev;
  assign w_any       = |w_rise;
  // Clearing the lowest set bit leaves something only if two or more lines rose.
  assign w_multi     = |(w_rise & (w_rise - 5'd1));
  assign w_contando  = (r_estado == CONTANDO);
  // Simultaneous rises collapse into a single null vote.
  assign w_inc       = !w_contando ? 5'b00000 : (w_multi ? 5'b10000 : w_rise);
  assign w_prox_rise = proximo && !r_prox_prev;

  // Select the candidate counter under scan and decide this step's tie flag.
  always_comb begin
    w_scan_cnt = 8'd0;
    case (r_scan_idx)
      2'd0: w_scan_cnt = r_cnt[0];
      2'd1: w_scan_cnt = r_cnt[1];
      2'd2: w_scan_cnt = r_cnt[2];
      2'd3: w_scan_cnt = r_cnt[3];
      default: w_scan_cnt = 8'd0;
    endcase
    w_gt          = (w_scan_cnt > r_best);
    w_empate_next = r_empate;
    if (w_gt)
      w_empate_next = 1'b0;
    else if ((w_scan_cnt == r_best) && (r_best != 8'd0))
      w_empate_next = 1'b1;
  end

  // Readout mux over the five counters.
  always_comb begin
    exibe_votos = 8'd0;
    case (r_exibe_idx)
      3'd0: exibe_votos = r_cnt[0];
      3'd1: exibe_votos = r_cnt[1];
      3'd2: exibe_votos = r_cnt[2];
      3'd3: exibe_votos = r_cnt[3];
      3'd4: exibe_votos = r_cnt[4];
      default: exibe_votos = 8'd0;
    endcase
  end

  // Previous-value registers for rising-edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cand_prev <= 5'd0;
      r_prox_prev <= 1'b0;
    end else begin
      r_cand_prev <= w_cand;
      r_prox_prev <= proximo;
    end
  end

  // Saturating vote counters and total; only move while counting.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 5; i++) r_cnt[i] <= 8'd0;
      r_total <= 10'd0;
    end else begin
      for (int i = 0; i < 5; i++)
        if (w_inc[i] && (r_cnt[i] != 8'hFF)) r_cnt[i] <= r_cnt[i] + 8'd1;
      if (w_contando && w_any && (r_total != 10'h3FF))
        r_total <= r_total + 10'd1;
    end
  end

  // Control FSM: counting, winner scan, result hold with readout stepping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado    <= CONTANDO;
      r_scan_idx  <= 2'd0;
      r_best      <= 8'd0;
      r_vencedor  <= NENHUM;
      r_empate    <= 1'b0;
      r_pronto    <= 1'b0;
      r_exibe_idx <= 3'd0;
    end else begin
      case (r_estado)
        CONTANDO: begin
          if (finish) begin
            r_estado   <= APURANDO;
            r_scan_idx <= 2'd0;
            r_best     <= 8'd0;
            r_empate   <= 1'b0;
            r_vencedor <= NENHUM;
          end
        end
        APURANDO: begin
          if (w_gt) begin
            r_best     <= w_scan_cnt;
            r_vencedor <= {1'b0, r_scan_idx};
          end
          r_empate   <= w_empate_next;
          r_scan_idx <= r_scan_idx + 2'd1;
          if (r_scan_idx == 2'd3) begin
            r_estado    <= RESULTADO;
            r_pronto    <= 1'b1;
            r_exibe_idx <= 3'd0;
            if (w_empate_next) r_vencedor <= NENHUM;
          end
        end
        RESULTADO: begin
          if (w_prox_rise)
            r_exibe_idx <= (r_exibe_idx == 3'd4) ? 3'd0 : r_exibe_idx + 3'd1;
        end
        default: begin
          r_estado <= CONTANDO;
          r_pronto <= 1'b0;
        end
      endcase
    end
  end

  assign estado      = r_estado;
  assign total_votos = r_total;
  assign vencedor    = r_vencedor;
  assign empate      = r_empate;
  assign pronto      = r_pronto;
  assign exibe_idx   = r_exibe_idx;

endmodule

// File: tb/tb_apuracao.sv
// Bench for apuracao: directed scenarios plus randomized elections compared
// against a plain arithmetic tally model.
module tb_apuracao;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] cand  = 5'd0;
  logic       finish = 1'b0;
  logic       proximo = 1'b0;
  logic [1:0] estado;
  logic [9:0] total_votos;
  logic [2:0] vencedor;
  logic       empate;
  logic       pronto;
  logic [2:0] exibe_idx;
  logic [7:0] exibe_votos;

  int checks = 0;
  int failures = 0;

  // model: counts per index (0..3 candidates, 4 nulo), total, previous levels
  int         m_cnt[5];
  int         m_total;
  logic [4:0] m_prev;
  bit         m_counting;

  always #5 clock = ~clock;

  apuracao dut (
    .clock(clock), .reset(reset),
    .candidatoArthur(cand[0]), .candidatoLeandro(cand[1]),
    .candidatoMateus(cand[2]), .candidatoPablo(cand[3]),
    .candidatoNulo(cand[4]), .finish(finish), .proximo(proximo),
    .estado(estado), .total_votos(total_votos), .vencedor(vencedor),
    .empate(empate), .pronto(pronto), .exibe_idx(exibe_idx),
    .exibe_votos(exibe_votos)
  );

  function automatic void model_clear();
    for (int i = 0; i < 5; i++) m_cnt[i] = 0;
    m_total = 0;
    m_prev = 5'd0;
    m_counting = 1'b1;
  endfunction

  // Winner from the final counts: the unique maximum, else 7.
  function automatic void exp_result(output int v, output int e);
    int mx = 0;
    int nmax = 0;
    for (int i = 0; i < 4; i++) if (m_cnt[i] > mx) mx = m_cnt[i];
    v = 7;
    for (int i = 0; i < 4; i++) if (m_cnt[i] == mx) begin nmax++; v = i; end
    if (mx == 0) begin v = 7; e = 0; end
    else if (nmax > 1) begin v = 7; e = 1; end
    else e = 0;
  endfunction

  // Drive one cycle (called at a negedge); returns at the following negedge.
  task automatic step(input logic [4:0] c, input logic f, input logic p);
    logic [4:0] r;
    int n;
    cand = c; finish = f; proximo = p;
    if (m_counting) begin
      r = c & ~m_prev;
      n = $countones(r);
      if (n == 1) begin
        for (int i = 0; i < 5; i++)
          if (r[i]) m_cnt[i] = (m_cnt[i] < 255) ? m_cnt[i] + 1 : 255;
      end else if (n >= 2) begin
        m_cnt[4] = (m_cnt[4] < 255) ? m_cnt[4] + 1 : 255;
      end
      if (n >= 1) m_total = (m_total < 1023) ? m_total + 1 : 1023;
      if (f) m_counting = 1'b0;
    end
    m_prev = c;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic pulse(input logic [4:0] c);
    step(c, 1'b0, 1'b0);
    step(5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0; cand = 5'd0; finish = 1'b0; proximo = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    model_clear();
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (pronto !== 1'b1 && n < 10) begin
      step(5'd0, 1'b0, 1'b0);
      n++;
    end
  endtask

  task automatic read_out(output int vals[5], output int idxs[5], output int idx_end);
    for (int i = 0; i < 5; i++) begin
      idxs[i] = int'(exibe_idx);
      vals[i] = int'(exibe_votos);
      step(5'd0, 1'b0, 1'b1);
      step(5'd0, 1'b0, 1'b0);
    end
    idx_end = int'(exibe_idx);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (estado !== 2'd0) begin failures++; $display("FAIL reset_estado got=%0d exp=0", estado); end
    checks++; if (total_votos !== 10'd0) begin failures++; $display("FAIL reset_total got=%0d exp=0", total_votos); end
    checks++; if (vencedor !== 3'd7) begin failures++; $display("FAIL reset_vencedor got=%0d exp=7", vencedor); end
    checks++; if (empate !== 1'b0 || pronto !== 1'b0) begin failures++; $display("FAIL reset_flags empate=%0b pronto=%0b exp=0,0", empate, pronto); end
    checks++; if (exibe_idx !== 3'd0 || exibe_votos !== 8'd0) begin failures++; $display("FAIL reset_exibe idx=%0d votos=%0d exp=0,0", exibe_idx, exibe_votos); end
  endtask

  // Finish, wait for the result, compare winner and readout against the model.
  task automatic run_election(input string name, input logic [4:0] fin_c);
    int n, v, e, idx_end;
    int vals[5];
    int idxs[5];
    step(fin_c, 1'b1, 1'b0);
    checks++; if (estado !== 2'd1) begin failures++; $display("FAIL %s_apurando got=%0d exp=1", name, estado); end
    wait_result(n);
    exp_result(v, e);
    checks++; if (n != 4 || estado !== 2'd2) begin failures++; $display("FAIL %s_latency got=%0d estado=%0d exp=4,2", name, n, estado); end
    checks++; if (int'(vencedor) != v || int'(empate) != e) begin failures++; $display("FAIL %s_vencedor got=%0d,%0d exp=%0d,%0d", name, vencedor, empate, v, e); end
    checks++; if (int'(total_votos) != m_total) begin failures++; $display("FAIL %s_total got=%0d exp=%0d", name, total_votos, m_total); end
    read_out(vals, idxs, idx_end);
    for (int i = 0; i < 5; i++) begin
      checks++; if (vals[i] != m_cnt[i] || idxs[i] != i) begin failures++; $display("FAIL %s_readout%0d idx=%0d votos=%0d exp=%0d,%0d", name, i, idxs[i], vals[i], i, m_cnt[i]); end
    end
    checks++; if (idx_end != 0) begin failures++; $display("FAIL %s_wrap got=%0d exp=0", name, idx_end); end
  endtask

  task automatic test_basic();
    do_reset();
    repeat (3) pulse(5'b00001);
    pulse(5'b00100);
    repeat (2) pulse(5'b10000);
    checks++; if (total_votos !== 10'd6) begin failures++; $display("FAIL basic_total6 got=%0d exp=6", total_votos); end
    run_election("basic", 5'd0);
    checks++; if (vencedor !== 3'd0) begin failures++; $display("FAIL basic_arthur got=%0d exp=0", vencedor); end
  endtask

  task automatic test_tie();
    do_reset();
    repeat (2) pulse(5'b00010);
    repeat (2) pulse(5'b01000);
    run_election("tie", 5'd0);
    checks++; if (vencedor !== 3'd7 || empate !== 1'b1) begin failures++; $display("FAIL tie_flag got=%0d,%0b exp=7,1", vencedor, empate); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    pulse(5'b01001);
    checks++; if (m_cnt[4] != 1 || m_cnt[0] != 0 || m_cnt[3] != 0 || total_votos !== 10'd1) begin failures++; $display("FAIL simult_model total=%0d exp=1", total_votos); end
    run_election("simult", 5'd0);
  endtask

  task automatic test_hold_saturation();
    do_reset();
    repeat (10) step(5'b00100, 1'b0, 1'b0);
    step(5'd0, 1'b0, 1'b0);
    checks++; if (total_votos !== 10'd1) begin failures++; $display("FAIL hold_total got=%0d exp=1", total_votos); end
    run_election("hold", 5'd0);
    do_reset();
    repeat (300) pulse(5'b00100);
    checks++; if (total_votos !== 10'd300) begin failures++; $display("FAIL sat_total300 got=%0d exp=300", total_votos); end
    for (int k = 0; k < 800; k++) begin
      case (k % 4)
        0: pulse(5'b00001);
        1: pulse(5'b00010);
        2: pulse(5'b01000);
        default: pulse(5'b10000);
      endcase
    end
    checks++; if (total_votos !== 10'd1023) begin failures++; $display("FAIL sat_total1023 got=%0d exp=1023", total_votos); end
    run_election("sat", 5'd0);
  endtask

  task automatic test_no_votes();
    int n;
    int e_idx;
    do_reset();
    step(5'd0, 1'b1, 1'b0);
    wait_result(n);
    checks++; if (vencedor !== 3'd7 || empate !== 1'b0 || pronto !== 1'b1) begin failures++; $display("FAIL novote_result got=%0d,%0b,%0b exp=7,0,1", vencedor, empate, pronto); end
    pulse(5'b00001);
    pulse(5'b00110);
    checks++; if (total_votos !== 10'd0 || estado !== 2'd2) begin failures++; $display("FAIL novote_frozen total=%0d estado=%0d exp=0,2", total_votos, estado); end
    for (int i = 1; i <= 5; i++) begin
      step(5'd0, 1'b0, 1'b1);
      step(5'd0, 1'b0, 1'b0);
      e_idx = i % 5;
      checks++; if (int'(exibe_idx) != e_idx) begin failures++; $display("FAIL novote_idx%0d got=%0d exp=%0d", i, exibe_idx, e_idx); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (2) pulse(5'b00001);
    step(5'd0, 1'b1, 1'b0);
    step(5'd0, 1'b0, 1'b0);
    checks++; if (estado !== 2'd1 || exibe_votos !== 8'd2) begin failures++; $display("FAIL areset_pre estado=%0d votos=%0d exp=1,2", estado, exibe_votos); end
    #1 reset = 1'b0;
    #1;
    checks++; if (estado !== 2'd0 || total_votos !== 10'd0 || exibe_votos !== 8'd0) begin failures++; $display("FAIL areset_now estado=%0d total=%0d votos=%0d exp=0,0,0", estado, total_votos, exibe_votos); end
    checks++; if (vencedor !== 3'd7 || pronto !== 1'b0 || empate !== 1'b0) begin failures++; $display("FAIL areset_out venc=%0d pronto=%0b empate=%0b exp=7,0,0", vencedor, pronto, empate); end
    @(negedge clock);
    reset = 1'b1;
    model_clear();
  endtask

  task automatic test_random();
    logic [4:0] c;
    int r;
    for (int round = 0; round < 6; round++) begin
      do_reset();
      for (int k = 0; k < int'($urandom_range(20, 120)); k++) begin
        r = int'($urandom_range(0, 3));
        if (r == 0) c = 5'd0;
        else if (r == 3) c = 5'($urandom_range(0, 31));
        else c = 5'b00001 << $urandom_range(0, 4);
        step(c, 1'b0, 1'($urandom_range(0, 1)));
      end
      checks++; if (exibe_idx !== 3'd0 || estado !== 2'd0) begin failures++; $display("FAIL rand%0d_idle idx=%0d estado=%0d exp=0,0", round, exibe_idx, estado); end
      run_election($sformatf("rand%0d", round), 5'($urandom_range(0, 31)));
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_basic();
    test_tie();
    test_simultaneous();
    test_hold_saturation();
    test_no_votes();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
